sm3_blk_collect: RTL and testbench
==================================

Name: sm3_blk_collect

Overview:
- Receiving end of the SM3 padded-word stream produced by the padding core.
- Packs the padded 32/64-bit words into 512-bit message blocks (W0..W15) and hands each block to the SM3 compression/expansion engine over a valid/ready handshake.
- Marks the first and last block of every message.
- Drives the block-level enable back to the padding core so the core can stall between blocks.

Parameters:
- INPT_DW, 64, stream word width; legal values 32 or 64.
- WPB, INPT_DW/32, 32-bit words per beat (derived; do not override).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
- pad_d_i  in  INPT_DW  padded data beat, big-endian (first word in MSBs).
- pad_vld_i  in  1  beat valid. No ready; every valid beat must be accepted.
- pad_lst_i  in  1  final beat of the message (carries the low length word).
- pad_ena_o  out  1  space available. Drives the padding core's output-enable input.
- blk_d_o  out  512  assembled block; W0 at [511:480], W15 at [31:0].
- blk_vld_o  out  1  block valid.
- blk_fst_o  out  1  block is the first of its message (engine loads IV).
- blk_lst_o  out  1  block is the last of its message (digest is final after it).
- blk_rdy_i  in  1  engine accepts the block.
- blk_cnt_o  out  16  blocks emitted for the current message, counting the presented block; 1-based.
- ovf_err_o  out  1  sticky overflow error.

Behaviour:
- Reset values: pad_ena_o=1, blk_vld_o=0, blk_fst_o=0, blk_lst_o=0, blk_d_o=0, blk_cnt_o=0, ovf_err_o=0. Internally, fst_pend=1.
- Reset mid-operation discards any partial block and any held block. No output pulses occur during reset.
- Storage:
  - Assembly buffer: 512 bits plus word counter asm_cnt (0..16, in 32-bit words).
  - Output holding register: blk_d_o with its flags.
- Assembly:
  - On pad_vld_i, write beat into words asm_cnt..asm_cnt+WPB-1, then asm_cnt += WPB.
  - Words are written MSB-first: word k lands at bits [511-32k -: 32].
  - If the beat has pad_lst_i=1, latch lst_seen.
- Block complete: asm_cnt reaches 16 (including the completing beat). Set asm_full.
- Transfer (assembly to holding register):
  - Occurs when asm_full and (blk_vld_o=0, or blk_vld_o & blk_rdy_i in the same cycle).
  - Effects: blk_vld_o<=1; blk_fst_o<=fst_pend; blk_lst_o<=lst_seen; blk_cnt_o<= fst_pend ? 1 : blk_cnt_o+1.
  - Clear asm_cnt, asm_full and lst_seen. fst_pend<=lst_seen.
  - A beat arriving in the transfer cycle goes to word 0 of the freshly cleared buffer. There is no lost cycle.
- Latency: completing beat at cycle t -> blk_vld_o=1 at t+1, if the holding register is free or being drained at t.
- Output handshake:
  - blk_vld_o stays high and blk_d_o/blk_fst_o/blk_lst_o/blk_cnt_o stay stable until blk_rdy_i=1.
  - On accept without a simultaneous transfer, blk_vld_o<=0.
  - Accept and transfer in the same cycle: back-to-back blocks, blk_vld_o stays 1.
- pad_ena_o (registered):
  - Next value = ~(next blk_vld_o & next asm_cnt >= 16-2*WPB).
  - This leaves skid room for the padding core's one-beat pipeline when it stalls on enable.
  - Padding beats after the last data beat are always absorbed, because they never exceed the 16-word block boundary.
- Overflow:
  - Condition: pad_vld_i while asm_full and no transfer this cycle.
  - Action: the beat is dropped and ovf_err_o<=1.
  - ovf_err_o clears only on reset.
- pad_lst_i with asm_cnt not reaching 16 is a protocol violation. The block is held unflushed, and detecting this is a bench assertion, not RTL behaviour.
- Simultaneous pad_lst_i-completed block and new message first beat: the new beat lands in the cleared buffer, and the next block carries fst=1.

Test Plan:
- 32-bit mode, "abc": beats 0x61626380, 13×0x0, 0x0, 0x00000018 (lst) -> one block 0x61626380_0000…_00000018, blk_fst_o=1, blk_lst_o=1, blk_cnt_o=1, blk_vld_o one cycle after the 16th beat.
- 64-bit mode, 2-block message (56-byte data + padding = 16 beats), blk_rdy_i tied 1 -> two blocks; first has fst=1/lst=0/cnt=1, second has fst=0/lst=1/cnt=2; W0 of block 1 equals the MSB half of beat 0.
- Backpressure: blk_rdy_i=0 for 40 cycles with streaming input -> pad_ena_o falls when asm_cnt reaches 12 (64b) or 14 (32b) with the holding register full; no ovf_err_o; blk_d_o stable throughout; the held block is released first on blk_rdy_i=1.
- Back-to-back messages A (1 block) and B (1 block), A's lst beat immediately followed by B's first beat -> B block has fst=1, cnt=1, and B's W0 is correct.
- Force a beat while asm_full and the holding register is full -> ovf_err_o=1 next cycle and stays 1; the held block is unchanged.
- Assert rst_n low mid-block (asm_cnt=6) and mid-hold -> all outputs return to their reset values; the next message's first block has fst=1.

Source files
------------

// File: rtl/sm3_blk_collect.sv
// Packs padded SM3 stream beats (32/64-bit) into 512-bit message blocks and
// presents them to the compression engine with first/last/count tags.
module sm3_blk_collect #(
    parameter  int INPT_DW = 64,
    localparam int WPB     = INPT_DW / 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [INPT_DW-1:0] pad_d_i,
    input  logic               pad_vld_i,
    input  logic               pad_lst_i,
    output logic               pad_ena_o,
    output logic [511:0]       blk_d_o,
    output logic               blk_vld_o,
    output logic               blk_fst_o,
    output logic               blk_lst_o,
    input  logic               blk_rdy_i,
    output logic [15:0]        blk_cnt_o,
    output logic               ovf_err_o
);

    localparam logic [4:0] WPB_W    = 5'(WPB);
    localparam logic [4:0] ENA_THR  = 5'(16 - 2 * WPB);
    localparam logic [4:0] FULL_CNT = 5'd16;

    logic [511:0] asm_buf_q, asm_buf_d;
    logic [4:0]   asm_cnt_q, asm_cnt_d;
    logic         asm_full_q, asm_full_d;
    logic         lst_seen_q, lst_seen_d;
    logic         fst_pend_q, fst_pend_d;
    logic [511:0] blk_d_q, blk_d_d;
    logic         blk_vld_q, blk_vld_d;
    logic         blk_fst_q, blk_fst_d;
    logic         blk_lst_q, blk_lst_d;
    logic [15:0]  blk_cnt_q, blk_cnt_d;
    logic         pad_ena_q, pad_ena_d;
    logic         ovf_err_q, ovf_err_d;

    logic         xfer;
    logic         accept;
    logic [4:0]   wr_base;

    assign xfer   = asm_full_q && (!blk_vld_q || blk_rdy_i);
    assign accept = blk_vld_q && blk_rdy_i;

    always_comb begin
        asm_buf_d  = asm_buf_q;
        asm_cnt_d  = asm_cnt_q;
        asm_full_d = asm_full_q;
        lst_seen_d = lst_seen_q;
        fst_pend_d = fst_pend_q;
        blk_d_d    = blk_d_q;
        blk_vld_d  = blk_vld_q;
        blk_fst_d  = blk_fst_q;
        blk_lst_d  = blk_lst_q;
        blk_cnt_d  = blk_cnt_q;
        ovf_err_d  = ovf_err_q;
        wr_base    = asm_cnt_q;

        if (xfer) begin
            blk_vld_d  = 1'b1;
            blk_d_d    = asm_buf_q;
            blk_fst_d  = fst_pend_q;
            blk_lst_d  = lst_seen_q;
            blk_cnt_d  = fst_pend_q ? 16'd1 : blk_cnt_q + 16'd1;
            fst_pend_d = lst_seen_q;
            asm_cnt_d  = 5'd0;
            asm_full_d = 1'b0;
            lst_seen_d = 1'b0;
            wr_base    = 5'd0;
        end else if (accept) begin
            blk_vld_d = 1'b0;
        end

        // A beat in the transfer cycle lands at word 0 of the cleared buffer.
        if (pad_vld_i) begin
            if (asm_full_q && !xfer) begin
                ovf_err_d = 1'b1;
            end else begin
                for (int w = 0; w < WPB; w++) begin
                    asm_buf_d[511 - 32 * (int'(wr_base) + w) -: 32] =
                        pad_d_i[INPT_DW - 1 - 32 * w -: 32];
                end
                asm_cnt_d = wr_base + WPB_W;
                if (asm_cnt_d == FULL_CNT) begin
                    asm_full_d = 1'b1;
                end
                if (pad_lst_i) begin
                    lst_seen_d = 1'b1;
                end
            end
        end

        // Drop enable early enough to absorb the padding core's in-flight beat.
        pad_ena_d = !(blk_vld_d && (asm_cnt_d >= ENA_THR));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            asm_buf_q  <= '0;
            asm_cnt_q  <= '0;
            asm_full_q <= 1'b0;
            lst_seen_q <= 1'b0;
            fst_pend_q <= 1'b1;
            blk_d_q    <= '0;
            blk_vld_q  <= 1'b0;
            blk_fst_q  <= 1'b0;
            blk_lst_q  <= 1'b0;
            blk_cnt_q  <= '0;
            pad_ena_q  <= 1'b1;
            ovf_err_q  <= 1'b0;
        end else begin
            asm_buf_q  <= asm_buf_d;
            asm_cnt_q  <= asm_cnt_d;
            asm_full_q <= asm_full_d;
            lst_seen_q <= lst_seen_d;
            fst_pend_q <= fst_pend_d;
            blk_d_q    <= blk_d_d;
            blk_vld_q  <= blk_vld_d;
            blk_fst_q  <= blk_fst_d;
            blk_lst_q  <= blk_lst_d;
            blk_cnt_q  <= blk_cnt_d;
            pad_ena_q  <= pad_ena_d;
            ovf_err_q  <= ovf_err_d;
        end
    end

    assign pad_ena_o = pad_ena_q;
    assign blk_d_o   = blk_d_q;
    assign blk_vld_o = blk_vld_q;
    assign blk_fst_o = blk_fst_q;
    assign blk_lst_o = blk_lst_q;
    assign blk_cnt_o = blk_cnt_q;
    assign ovf_err_o = ovf_err_q;

endmodule

// File: tb/tb_sm3_blk_collect.sv
// Directed bench for sm3_blk_collect: one 32-bit and one 64-bit instance
// sharing clock and reset.
module tb_sm3_blk_collect;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [31:0]  d32 = '0;
    logic         v32 = 1'b0, l32 = 1'b0, r32 = 1'b0;
    logic         ena32, bv32, bf32, bl32, ov32;
    logic [511:0] bd32;
    logic [15:0]  bc32;

    logic [63:0]  d64 = '0;
    logic         v64 = 1'b0, l64 = 1'b0, r64 = 1'b0;
    logic         ena64, bv64, bf64, bl64, ov64;
    logic [511:0] bd64;
    logic [15:0]  bc64;

    sm3_blk_collect #(.INPT_DW(32)) u32 (
        .clk(clk), .rst_n(rst_n), .pad_d_i(d32), .pad_vld_i(v32), .pad_lst_i(l32),
        .pad_ena_o(ena32), .blk_d_o(bd32), .blk_vld_o(bv32), .blk_fst_o(bf32),
        .blk_lst_o(bl32), .blk_rdy_i(r32), .blk_cnt_o(bc32), .ovf_err_o(ov32)
    );

    sm3_blk_collect #(.INPT_DW(64)) u64 (
        .clk(clk), .rst_n(rst_n), .pad_d_i(d64), .pad_vld_i(v64), .pad_lst_i(l64),
        .pad_ena_o(ena64), .blk_d_o(bd64), .blk_vld_o(bv64), .blk_fst_o(bf64),
        .blk_lst_o(bl64), .blk_rdy_i(r64), .blk_cnt_o(bc64), .ovf_err_o(ov64)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int wc32 = 0;
    int wc64 = 0;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Last beat must close a 16-word block; anything else is a stimulus bug.
    task automatic b32(input logic [31:0] d, input logic l);
        if (l) assert ((wc32 + 1) % 16 == 0) else begin
            n_fail++;
            $error("FAIL proto32: lst at word %0d required block end", wc32);
        end
        wc32 += 1;
        d32 = d; v32 = 1'b1; l32 = l;
        tick();
        v32 = 1'b0; l32 = 1'b0;
    endtask

    task automatic b64(input logic [63:0] d, input logic l);
        if (l) assert ((wc64 + 2) % 16 == 0) else begin
            n_fail++;
            $error("FAIL proto64: lst at word %0d required block end", wc64);
        end
        wc64 += 2;
        d64 = d; v64 = 1'b1; l64 = l;
        tick();
        v64 = 1'b0; l64 = 1'b0;
    endtask

    function automatic logic [63:0] pat64(input int k);
        return {32'hA000_0000 + 32'(2 * k), 32'hA000_0000 + 32'(2 * k + 1)};
    endfunction

    function automatic logic [63:0] patb(input int k);
        return {32'hB000_0000 + 32'(2 * k), 32'hB000_0000 + 32'(2 * k + 1)};
    endfunction

    function automatic logic [511:0] blk_pat(input int base);
        logic [511:0] r;
        r = '0;
        for (int w = 0; w < 16; w++) r[511 - 32 * w -: 32] = 32'hA000_0000 + 32'(base + w);
        return r;
    endfunction

    task automatic chk_reset(input string tag);
        chk({tag, "_ena32"}, ena32, 1'b1);
        chk({tag, "_vld32"}, bv32, 1'b0);
        chk({tag, "_d32"}, bd32, '0);
        chk({tag, "_ena64"}, ena64, 1'b1);
        chk({tag, "_vld64"}, bv64, 1'b0);
        chk({tag, "_fst64"}, bf64, 1'b0);
        chk({tag, "_lst64"}, bl64, 1'b0);
        chk({tag, "_d64"}, bd64, '0);
        chk({tag, "_cnt64"}, bc64, 16'd0);
        chk({tag, "_ovf64"}, ov64, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        wc32 = 0; wc64 = 0;
        tick();
        rst_n = 1'b1;
    endtask

    logic [511:0] abc_exp;
    int sent, bad;

    initial begin
        abc_exp = {32'h6162_6380, 448'h0, 32'h0000_0018};

        repeat (2) @(posedge clk);
        #1;
        chk_reset("rst_in");
        rst_n = 1'b1;
        tick();
        chk_reset("rst_out");

        // 32-bit "abc": single block, first and last.
        b32(32'h6162_6380, 1'b0);
        for (int i = 0; i < 14; i++) b32(32'h0, 1'b0);
        b32(32'h0000_0018, 1'b1);
        chk("abc_vld_early", bv32, 1'b0);
        tick();
        chk("abc_vld", bv32, 1'b1);
        chk("abc_data", bd32, abc_exp);
        chk("abc_fst", bf32, 1'b1);
        chk("abc_lst", bl32, 1'b1);
        chk("abc_cnt", bc32, 16'd1);
        r32 = 1'b1;
        tick();
        r32 = 1'b0;
        chk("abc_drain", bv32, 1'b0);

        // 64-bit two-block message, engine always ready.
        do_reset();
        r64 = 1'b1;
        for (int i = 0; i < 16; i++) begin
            b64(pat64(i), i == 15);
            if (i == 8) begin
                chk("m2_b1_vld", bv64, 1'b1);
                chk("m2_b1_data", bd64, blk_pat(0));
                chk("m2_b1_w0", bd64[511:480], 32'hA000_0000);
                chk("m2_b1_fst", bf64, 1'b1);
                chk("m2_b1_lst", bl64, 1'b0);
                chk("m2_b1_cnt", bc64, 16'd1);
            end
            if (i == 9) chk("m2_b1_gone", bv64, 1'b0);
        end
        tick();
        chk("m2_b2_vld", bv64, 1'b1);
        chk("m2_b2_data", bd64, blk_pat(16));
        chk("m2_b2_fst", bf64, 1'b0);
        chk("m2_b2_lst", bl64, 1'b1);
        chk("m2_b2_cnt", bc64, 16'd2);
        tick();
        chk("m2_b2_gone", bv64, 1'b0);
        r64 = 1'b0;

        // 64-bit backpressure: enable honoured, enable drops at 12 words.
        do_reset();
        sent = 0; bad = 0;
        for (int c = 0; c < 40; c++) begin
            if (ena64) begin
                b64(pat64(sent), 1'b0);
                sent++;
            end else begin
                tick();
            end
            if (bv64 && bd64 !== blk_pat(0)) bad++;
        end
        chk("bp64_sent", sent, 14);
        chk("bp64_ena", ena64, 1'b0);
        chk("bp64_ovf", ov64, 1'b0);
        chk("bp64_stable", bad, 0);
        chk("bp64_held", bd64, blk_pat(0));
        r64 = 1'b1;
        tick();
        r64 = 1'b0;
        chk("bp64_rel_vld", bv64, 1'b0);
        chk("bp64_rel_ena", ena64, 1'b1);
        b64(pat64(14), 1'b0);
        b64(pat64(15), 1'b0);
        tick();
        chk("bp64_b2_vld", bv64, 1'b1);
        chk("bp64_b2_data", bd64, blk_pat(16));
        chk("bp64_b2_cnt", bc64, 16'd2);
        chk("bp64_b2_fst", bf64, 1'b0);

        // 32-bit backpressure: enable drops at 14 words.
        do_reset();
        sent = 0; bad = 0;
        for (int c = 0; c < 40; c++) begin
            if (ena32) begin
                b32(32'hA000_0000 + 32'(sent), 1'b0);
                sent++;
            end else begin
                tick();
            end
            if (bv32 && bd32 !== blk_pat(0)) bad++;
        end
        chk("bp32_sent", sent, 30);
        chk("bp32_ena", ena32, 1'b0);
        chk("bp32_ovf", ov32, 1'b0);
        chk("bp32_stable", bad, 0);
        chk("bp32_vld", bv32, 1'b1);

        // Back-to-back single-block messages A then B.
        do_reset();
        r64 = 1'b1;
        for (int i = 0; i < 8; i++) b64(pat64(i), i == 7);
        for (int i = 0; i < 8; i++) begin
            b64(patb(i), i == 7);
            if (i == 0) begin
                chk("bb_a_data", bd64, blk_pat(0));
                chk("bb_a_fst", bf64, 1'b1);
                chk("bb_a_lst", bl64, 1'b1);
                chk("bb_a_cnt", bc64, 16'd1);
            end
        end
        tick();
        chk("bb_b_vld", bv64, 1'b1);
        chk("bb_b_fst", bf64, 1'b1);
        chk("bb_b_lst", bl64, 1'b1);
        chk("bb_b_cnt", bc64, 16'd1);
        chk("bb_b_w0", bd64[511:480], 32'hB000_0000);
        chk("bb_b_w15", bd64[31:0], 32'hB000_000F);
        r64 = 1'b0;

        // Overflow: beat with assembly full and holding register full.
        do_reset();
        for (int i = 0; i < 16; i++) b64(pat64(i), 1'b0);
        chk("ovf_pre", ov64, 1'b0);
        b64(pat64(16), 1'b0);
        chk("ovf_set", ov64, 1'b1);
        chk("ovf_vld", bv64, 1'b1);
        chk("ovf_held", bd64, blk_pat(0));
        tick();
        tick();
        chk("ovf_sticky", ov64, 1'b1);
        r64 = 1'b1;
        tick();
        r64 = 1'b0;
        chk("ovf_b2_data", bd64, blk_pat(16));
        chk("ovf_b2_cnt", bc64, 16'd2);

        // Reset while a block is held.
        rst_n = 1'b0;
        wc64 = 0; wc32 = 0;
        #2;
        chk_reset("rst_hold");
        tick();
        rst_n = 1'b1;

        // Reset mid-block, then a fresh message must start at fst=1.
        for (int i = 0; i < 3; i++) b64(patb(i), 1'b0);
        rst_n = 1'b0;
        wc64 = 0;
        #2;
        chk("rst_mid_vld", bv64, 1'b0);
        chk("rst_mid_ena", ena64, 1'b1);
        tick();
        rst_n = 1'b1;
        r64 = 1'b1;
        for (int i = 0; i < 8; i++) b64(pat64(i), i == 7);
        tick();
        chk("post_rst_vld", bv64, 1'b1);
        chk("post_rst_fst", bf64, 1'b1);
        chk("post_rst_cnt", bc64, 16'd1);
        chk("post_rst_data", bd64, blk_pat(0));
        chk("post_rst_ovf", ov64, 1'b0);
        r64 = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
